mvm_stream: RTL and testbench
=============================

MVM_STREAM -- requirements
Module: mvm_stream

Interface
REQ-001 Parameter K, default 8: matrix dimension; A is KxK, x and y have K elements; K >= 2.
REQ-002 Parameter B, default 8: signed element width of A and x.
REQ-003 Derived parameter LK, default $clog2(K): index width.
REQ-004 Derived parameter AW, default 2*B+LK: signed accumulator and output width.
REQ-005 Port clk  in  1  rising-edge clock.
REQ-006 Port reset  in  1  reset, synchronous, active-high.
REQ-007 Port load_matrix  in  1  command: begin loading A.
REQ-008 Port load_vector  in  1  command: begin loading x.
REQ-009 Port start  in  1  command: begin computing y = A*x.
REQ-010 Port in_valid  in  1  data_in carries a valid element.
REQ-011 Port in_ready  out  1  block accepts data_in this cycle.
REQ-012 Port data_in  in  B  signed element.
REQ-013 Port out_valid  out  1  data_out carries a valid y element.
REQ-014 Port out_ready  in  1  consumer accepts data_out.
REQ-015 Port data_out  out  AW  signed y element.
REQ-016 Port busy  out  1  high in every state except IDLE.
REQ-017 Port done  out  1  one-cycle pulse after the last y element is accepted.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD_A, LOAD_X, COMPUTE, DRAIN, OUTPUT.
REQ-019 Commands are sampled only in IDLE; priority load_matrix > load_vector > start; commands in other states are ignored.
REQ-020 IDLE->LOAD_A on load_matrix, ->LOAD_X on load_vector, ->COMPUTE on start, on the following edge.
REQ-021 in_ready is high only in LOAD_A and LOAD_X; an element transfers when in_valid and in_ready are both high; gaps in in_valid stall the load counter.
REQ-022 LOAD_A stores K*K transfers row-major (element n -> A[n/K][n%K]), then returns to IDLE the cycle after transfer K*K.
REQ-023 LOAD_X stores K transfers to x[0..K-1], then returns to IDLE.
REQ-024 COMPUTE issues one A*x product per cycle through a registered multiplier and registered accumulator; the accumulator clears at the start of each row.
REQ-025 Products and sums are full-precision signed; AW bits never overflow for any inputs.
REQ-026 Row i's sum is written to y[i]; DRAIN waits for the pipeline to empty, then enters OUTPUT.
REQ-027 The first out_valid rises no more than K*K+K+4 cycles after the cycle start is sampled.
REQ-028 OUTPUT presents y[0..K-1] in order; the index advances only on out_valid and out_ready.
REQ-029 While out_valid is high and out_ready low, data_out SHALL be held stable.
REQ-030 After y[K-1] transfers, done pulses one cycle and the FSM returns to IDLE.
REQ-031 A and x contents persist across operations and reset; repeated start without reload recomputes the same y.

Reset
REQ-032 reset has priority over all inputs, forces IDLE, clears counters and accumulator, and aborts any load or compute in progress.
REQ-033 Reset values: in_ready=0, out_valid=0, busy=0, done=0, data_out=0.
REQ-034 After a mid-load reset, the partially written A or x content is undefined until reloaded.

Configuration
REQ-035 With macro MVM_STREAM_RELU_EN defined, each y element is clamped to 0 when negative before storage; without it, signed y passes unchanged.

Verification (K=4, B=8, AW=18)
REQ-036 A=identity, x=[1,2,3,4], start, out_ready=1 -> data_out 1,2,3,4, then a done pulse.
REQ-037 All A and x elements = -128 -> each y = 65536 with no overflow; with ReLU, the same result.
REQ-038 A=-identity, x=[5,6,7,8] -> y=[-5,-6,-7,-8] without the macro, y=[0,0,0,0] with it.
REQ-039 out_ready is low for 3 cycles while y[1] is presented -> data_out holds y[1], no element is lost or duplicated, done is delayed 3 cycles.
REQ-040 Reset is asserted 5 cycles into COMPUTE -> next cycle busy=0, out_valid=0; a later start without reload yields the correct y.
REQ-041 in_valid toggles every other cycle during LOAD_A; load_vector and start are pulsed during LOAD_A -> ignored; A loads correctly after 32 cycles.

Source files
------------

// File: rtl/mvm_stream.sv
// rtl/mvm_stream.sv - streaming KxK signed matrix-vector multiply (optional macro MVM_STREAM_RELU_EN)
module mvm_stream #(
    parameter int K  = 8,
    parameter int B  = 8,
    parameter int LK = $clog2(K),
    parameter int AW = 2*B + LK
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_matrix,
    input  logic                 load_vector,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [B-1:0]  data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [AW-1:0] data_out,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_X,
        COMPUTE,
        DRAIN,
        OUTPUT
    } state_t;

    localparam logic [LK-1:0] LAST = LK'(K - 1);

    state_t state;

    // A, x and y deliberately have no reset so loaded operands survive reset
    logic signed [B-1:0]  a_mem [K][K];
    logic signed [B-1:0]  x_mem [K];
    logic signed [AW-1:0] y_mem [K];

    // Row/column counters shared by loading and computing; oi walks the output
    logic [LK-1:0] ri;
    logic [LK-1:0] ci;
    logic [LK-1:0] oi;

    // Stage 1: registered product and its row bookkeeping
    logic                  v1;
    logic                  f1;
    logic                  l1;
    logic [LK-1:0]         r1;
    logic signed [2*B-1:0] prod;
    // Stage 2: registered accumulator
    logic                  v2;
    logic                  l2;
    logic [LK-1:0]         r2;
    logic signed [AW-1:0]  acc;

    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] y_val;
    logic                 xfer;

    assign prod_ext = {{(AW-2*B){prod[2*B-1]}}, prod};
    assign xfer     = in_valid && in_ready;

    // Optional clamp of negative row sums before they are stored
    always_comb begin
`ifdef MVM_STREAM_RELU_EN
        y_val = acc[AW-1] ? '0 : acc;
`else
        y_val = acc;
`endif
    end

    // Operand storage: element writes while a load is in progress
    always_ff @(posedge clk) begin
        if (!reset && xfer && state == LOAD_A)
            a_mem[ri][ci] <= data_in;
        if (!reset && xfer && state == LOAD_X)
            x_mem[ci] <= data_in;
    end

    // Result storage: write a row sum when its last product leaves the accumulator
    always_ff @(posedge clk) begin
        if (!reset && v2 && l2)
            y_mem[r2] <= y_val;
    end

    // Control FSM, multiply/accumulate pipeline and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ri        <= '0;
            ci        <= '0;
            oi        <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            data_out  <= '0;
            v1        <= 1'b0;
            f1        <= 1'b0;
            l1        <= 1'b0;
            r1        <= '0;
            prod      <= '0;
            v2        <= 1'b0;
            l2        <= 1'b0;
            r2        <= '0;
            acc       <= '0;
        end else begin
            done <= 1'b0;
            v1   <= 1'b0;
            v2   <= v1;
            l2   <= l1;
            r2   <= r1;
            if (v1)
                acc <= f1 ? prod_ext : acc + prod_ext;

            case (state)
                IDLE: begin
                    ri <= '0;
                    ci <= '0;
                    if (load_matrix) begin
                        state    <= LOAD_A;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end else if (load_vector) begin
                        state    <= LOAD_X;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end else if (start) begin
                        state <= COMPUTE;
                        busy  <= 1'b1;
                    end
                end

                LOAD_A: begin
                    if (xfer) begin
                        if (ci == LAST) begin
                            ci <= '0;
                            if (ri == LAST) begin
                                ri       <= '0;
                                state    <= IDLE;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                            end else begin
                                ri <= ri + 1'b1;
                            end
                        end else begin
                            ci <= ci + 1'b1;
                        end
                    end
                end

                LOAD_X: begin
                    if (xfer) begin
                        if (ci == LAST) begin
                            ci       <= '0;
                            state    <= IDLE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            ci <= ci + 1'b1;
                        end
                    end
                end

                COMPUTE: begin
                    v1   <= 1'b1;
                    f1   <= (ci == '0);
                    l1   <= (ci == LAST);
                    r1   <= ri;
                    prod <= a_mem[ri][ci] * x_mem[ci];
                    if (ci == LAST) begin
                        ci <= '0;
                        if (ri == LAST) begin
                            ri    <= '0;
                            state <= DRAIN;
                        end else begin
                            ri <= ri + 1'b1;
                        end
                    end else begin
                        ci <= ci + 1'b1;
                    end
                end

                DRAIN: begin
                    if (!v1 && !v2) begin
                        state     <= OUTPUT;
                        out_valid <= 1'b1;
                        data_out  <= y_mem[0];
                        oi        <= '0;
                    end
                end

                OUTPUT: begin
                    if (out_ready) begin
                        if (oi == LAST) begin
                            oi        <= '0;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            oi       <= oi + 1'b1;
                            data_out <= y_mem[oi + 1'b1];
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_stream.sv
// tb/tb_mvm_stream.sv - directed self-checking bench for mvm_stream (K=4, B=8)
module tb_mvm_stream;

    localparam int K  = 4;
    localparam int B  = 8;
    localparam int AW = 18;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 load_matrix = 1'b0;
    logic                 load_vector = 1'b0;
    logic                 start = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [B-1:0]  data_in = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [AW-1:0] data_out;
    logic                 busy;
    logic                 done;

    int n_cmp = 0;
    int n_err = 0;

    mvm_stream #(.K(K), .B(B)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_matrix (load_matrix),
        .load_vector (load_vector),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_in     (data_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_a(input int m [16], input bit gaps);
        int cyc;
        cyc = 0;
        load_matrix = 1'b1;
        tick();
        load_matrix = 1'b0;
        chk("load_a_in_ready", in_ready, 1);
        for (int n = 0; n < 16; n++) begin
            if (gaps) begin
                in_valid    = 1'b0;
                load_vector = 1'b1;
                start       = 1'b1;
                tick();
                cyc++;
                load_vector = 1'b0;
                start       = 1'b0;
                if (n == 15) chk("load_a_gap_ready", in_ready, 1);
            end
            in_valid = 1'b1;
            data_in  = 8'(m[n]);
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        if (gaps) chk("load_a_cycles", cyc, 32);
        chk("load_a_idle_busy", busy, 0);
        chk("load_a_idle_ready", in_ready, 0);
    endtask

    task automatic load_x(input int v [4]);
        load_vector = 1'b1;
        tick();
        load_vector = 1'b0;
        for (int n = 0; n < 4; n++) begin
            in_valid = 1'b1;
            data_in  = 8'(v[n]);
            tick();
        end
        in_valid = 1'b0;
        chk("load_x_idle_busy", busy, 0);
    endtask

    task automatic run(input string tag, input int exp [4], input int stall_idx);
        int cyc;
        int span;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("%s_busy", tag), busy, 1);
        cyc = 1;
        while (!out_valid && cyc < 60) begin
            tick();
            cyc++;
        end
        chk($sformatf("%s_latency_ok", tag), (cyc <= K*K+K+4), 1);
        if (!out_valid) return;
        span = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    span++;
                    chk($sformatf("%s_hold%0d", tag, s), data_out, exp[i]);
                end
                out_ready = 1'b1;
            end
            chk($sformatf("%s_valid%0d", tag, i), out_valid, 1);
            chk($sformatf("%s_y%0d", tag, i), data_out, exp[i]);
            chk($sformatf("%s_done_early%0d", tag, i), done, 0);
            tick();
            span++;
        end
        chk($sformatf("%s_done", tag), done, 1);
        chk($sformatf("%s_span", tag), span, (stall_idx >= 0) ? 7 : 4);
        chk($sformatf("%s_out_valid_low", tag), out_valid, 0);
        tick();
        chk($sformatf("%s_done_pulse", tag), done, 0);
        chk($sformatf("%s_idle", tag), busy, 0);
    endtask

    initial begin
        int ident [16];
        int nident [16];
        int neg [16];
        int ramp [16];
        int x1 [4];
        int xneg [4];
        int x5 [4];
        int x4 [4];
        int e_id [4];
        int e_neg [4];
        int e_nid [4];
        int e_ramp [4];

        ident  = '{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1};
        nident = '{-1,0,0,0, 0,-1,0,0, 0,0,-1,0, 0,0,0,-1};
        neg    = '{default: -128};
        for (int n = 0; n < 16; n++) ramp[n] = n - 8;
        x1     = '{1, 2, 3, 4};
        xneg   = '{default: -128};
        x5     = '{5, 6, 7, 8};
        x4     = '{1, -2, 3, -4};
        e_id   = '{1, 2, 3, 4};
        e_neg  = '{65536, 65536, 65536, 65536};
`ifdef MVM_STREAM_RELU_EN
        e_nid  = '{0, 0, 0, 0};
        e_ramp = '{8, 0, 0, 0};
`else
        e_nid  = '{-5, -6, -7, -8};
        e_ramp = '{8, 0, -8, -16};
`endif

        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data_out", data_out, 0);
        reset = 1'b0;
        tick();

        load_a(ident, 1'b0);
        load_x(x1);
        run("identity", e_id, -1);

        load_a(neg, 1'b0);
        load_x(xneg);
        run("all_min", e_neg, -1);

        load_a(nident, 1'b0);
        load_x(x5);
        run("neg_identity", e_nid, -1);

        load_a(ramp, 1'b1);
        load_x(x4);
        run("ramp_gapped", e_ramp, -1);
        run("ramp_stall", e_ramp, 1);

        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("mid_compute_busy", busy, 1);
        reset = 1'b1;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_done", done, 0);
        reset = 1'b0;
        tick();
        run("after_abort", e_ramp, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
